if_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the MIPS32 IF stage. Owns the PC register (word-addressed, +1 per instr),

---
 rtl/mips32_if_pkg.sv | 14 +
 rtl/if_pc_incr.sv | 13 +
 rtl/if_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_if_fetch_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_if_pkg.sv
// Shared types and constants for the MIPS32 instruction-fetch stage.
package mips32_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SQUASH
  } fetch_state_t;

  localparam int          PC_INC           = 1;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_pc_incr.sv
// Word-address incrementer; wraps modulo 2^PC_W with no carry out.
module if_pc_incr
  import mips32_if_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_inc
);

  assign pc_inc = pc + PC_W'(PC_INC);

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: PC register, single-outstanding imem requests,
// one-entry instruction buffer toward ID, and redirect/squash handling.
module if_fetch_ctrl
  import mips32_if_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc_next,
  input  logic               id_ready
);

  fetch_state_t        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, pc_plus1;
  logic                buf_valid_q;
  logic [INSTR_W-1:0]  buf_instr_q;
  logic [PC_W-1:0]     buf_pc_q;
  logic                load_buf;

  if_pc_incr #(.PC_W(PC_W)) u_pc_incr (
    .pc     (pc_q),
    .pc_inc (pc_plus1)
  );

  if_pc_incr #(.PC_W(PC_W)) u_next_incr (
    .pc     (buf_pc_q),
    .pc_inc (if_pc_next)
  );

  // Request only when the buffer is guaranteed free by the time data returns.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    load_buf = 1'b0;
    imem_req = (state_q == ST_REQ) && (!buf_valid_q || id_ready);

    case (state_q)
      ST_IDLE: begin
        if (fetch_en && !redirect_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_req && imem_gnt) begin
          state_d = redirect_valid ? ST_SQUASH : ST_WAIT;
          pc_d    = pc_plus1;
        end else if (!fetch_en && !redirect_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          load_buf = !redirect_valid;
          state_d  = fetch_en ? ST_REQ : ST_IDLE;
        end else if (redirect_valid) begin
          state_d = ST_SQUASH;
        end
      end
      ST_SQUASH: begin
        if (imem_rvalid) state_d = fetch_en ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect_valid) pc_d = redirect_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // pc_q has already advanced past the outstanding fetch, so its PC is pc_q-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      if (redirect_valid)            buf_valid_q <= 1'b0;
      else if (load_buf)             buf_valid_q <= 1'b1;
      else if (buf_valid_q && id_ready) buf_valid_q <= 1'b0;

      if (load_buf) begin
        buf_instr_q <= imem_rdata;
        buf_pc_q    <= pc_q - PC_W'(PC_INC);
      end
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = buf_valid_q;
  assign if_instr  = buf_instr_q;
  assign if_pc     = buf_pc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a transaction-level fetch model and imem responder.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_ready = 1'b1;

  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc, if_pc_next;
  logic        d2_imem_req, d2_if_valid;
  logic [31:0] d2_imem_addr, d2_if_instr, d2_if_pc, d2_if_pc_next;

  if_fetch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_next(if_pc_next), .id_ready(id_ready)
  );

  if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFF)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(d2_imem_req), .imem_addr(d2_imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(d2_if_valid), .if_instr(d2_if_instr), .if_pc(d2_if_pc),
    .if_pc_next(d2_if_pc_next), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic checking = 1'b0;

  // Model: running = issuing requests, pend = access in flight, drop = its data is void.
  logic        m_run, m_pend, m_drop, m_bv;
  logic [31:0] m_pc, m_pend_pc, m_bpc, m_binstr;

  // Responder state and observation queues.
  int          lat = 1;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = '0;
  logic [31:0] q_addr[$], q_pc[$], q_next[$], q2_addr[$];
  logic        d2_seen = 1'b0;
  logic [31:0] d2_first_pc = 'x, d2_first_next = 'x, d2_first_instr = 'x;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout waiting for condition at %0t", nm, $time);
  endtask

  task automatic model_step();
    logic req, cons, deliver;
    if (!rst_n) begin
      m_run = 0; m_pend = 0; m_drop = 0; m_bv = 0;
      m_pc = 32'h0; m_pend_pc = 32'h0; m_bpc = 32'h0; m_binstr = 32'h0;
      return;
    end
    req     = m_run && (!m_bv || id_ready);
    cons    = m_bv && id_ready;
    deliver = 1'b0;
    if (m_pend) begin
      if (imem_rvalid) begin
        deliver = !m_drop && !redirect_valid;
        m_pend  = 0;
        m_drop  = 0;
        m_run   = fetch_en;
      end else if (redirect_valid) begin
        m_drop = 1;
      end
    end else if (m_run) begin
      if (req && imem_gnt) begin
        m_pend    = 1;
        m_drop    = redirect_valid;
        m_run     = 0;
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd1;
      end else if (!fetch_en && !redirect_valid) begin
        m_run = 0;
      end
    end else begin
      m_run = fetch_en && !redirect_valid;
    end
    if (redirect_valid) m_pc = redirect_pc;
    if (redirect_valid) m_bv = 0;
    else if (deliver) begin
      m_bv = 1; m_binstr = imem_rdata; m_bpc = m_pend_pc;
    end else if (cons) m_bv = 0;
  endtask

  // Every cycle: DUT outputs against the model state after the last edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("imem_req", 32'(imem_req), 32'(m_run && (!m_bv || id_ready)));
      chk("imem_addr", imem_addr, m_pc);
      chk("if_valid", 32'(if_valid), 32'(m_bv));
      if (m_bv) begin
        chk("if_instr", if_instr, m_binstr);
        chk("if_pc", if_pc, m_bpc);
        chk("if_pc_next", if_pc_next, m_bpc + 32'd1);
      end
    end
  end

  task automatic cycle_begin();
    @(negedge clk);
    #2;
    if (!rst_n) begin
      resp_cnt = 0; imem_rvalid = 0;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      imem_rvalid = (resp_cnt == 0);
      imem_rdata  = mem_word(resp_addr);
    end else begin
      imem_rvalid = 0;
    end
  endtask

  task automatic cycle_end();
    #1;
    if (imem_req && imem_gnt) begin
      q_addr.push_back(imem_addr);
      resp_addr = imem_addr;
      resp_cnt  = lat;
    end
    if (d2_imem_req && imem_gnt) q2_addr.push_back(d2_imem_addr);
    if (if_valid && id_ready) begin
      q_pc.push_back(if_pc);
      q_next.push_back(if_pc_next);
    end
    if (d2_if_valid && !d2_seen) begin
      d2_seen = 1; d2_first_pc = d2_if_pc; d2_first_next = d2_if_pc_next;
      d2_first_instr = d2_if_instr;
    end
    model_step();
  endtask

  task automatic next();
    cycle_end();
    cycle_begin();
  endtask

  task automatic clear_q();
    q_addr.delete(); q_pc.delete(); q_next.delete();
  endtask

  initial begin
    int n;
    cycle_begin();
    // Reset values while rst_n is held low
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc_next", if_pc_next, 32'h1);
    chk("rst_wrap_addr", d2_imem_addr, 32'hFFFF_FFFF);
    next();
    checking = 1;
    rst_n = 1; fetch_en = 1; id_ready = 1; lat = 1;

    // Streaming fetch
    n = 0;
    while (q_pc.size() < 3 && n < 40) begin next(); n++; end
    if (n >= 40) timeout("t1_stream");
    chk("t1_addr0", qat(q_addr, 0), 32'd0);
    chk("t1_addr1", qat(q_addr, 1), 32'd1);
    chk("t1_addr2", qat(q_addr, 2), 32'd2);
    chk("t1_pc0", qat(q_pc, 0), 32'd0);
    chk("t1_pc2", qat(q_pc, 2), 32'd2);
    chk("t1_next0", qat(q_next, 0), 32'd1);
    chk("t1_next2", qat(q_next, 2), 32'd3);
    chk("t5_wrap_addr0", qat(q2_addr, 0), 32'hFFFF_FFFF);
    chk("t5_wrap_addr1", qat(q2_addr, 1), 32'h0000_0000);
    chk("t5_wrap_pc", d2_first_pc, 32'hFFFF_FFFF);
    chk("t5_wrap_next", d2_first_next, 32'h0000_0000);
    chk("t5_wrap_instr", d2_first_instr, 32'hA500_0000);

    // Back-pressure from ID
    n = 0;
    while (!(m_run && m_bv) && n < 40) begin next(); n++; end
    if (n >= 40) timeout("t2_wait");
    id_ready = 0;
    #1;
    chk("t2_req_low", 32'(imem_req), 32'd0);
    for (int i = 0; i < 3; i++) next();
    chk("t2_hold_valid", 32'(if_valid), 32'd1);
    chk("t2_hold_pc", if_pc, 32'd3);
    lat = 2;
    id_ready = 1;
    #1;
    chk("t2_req_resume", 32'(imem_req), 32'd1);
    chk("t2_addr_resume", imem_addr, 32'd4);
    next();

    // Redirect while waiting for data (pc_q = 5)
    n = 0;
    while (!(m_pend && !m_drop && m_pc == 32'd5) && n < 40) begin next(); n++; end
    if (n >= 40) timeout("t3_wait");
    redirect_valid = 1; redirect_pc = 32'h100;
    next();
    redirect_valid = 0;
    clear_q();
    chk("t3_valid_cleared", 32'(if_valid), 32'd0);
    next();
    chk("t3_dropped", 32'(if_valid), 32'd0);
    chk("t3_addr", imem_addr, 32'h100);
    n = 0;
    while (q_pc.size() < 1 && n < 40) begin next(); n++; end
    if (n >= 40) timeout("t3_refetch");
    chk("t3_req_addr", qat(q_addr, 0), 32'h100);
    chk("t3_if_pc", qat(q_pc, 0), 32'h100);

    // Redirect in the same cycle as the response
    lat = 1;
    n = 0;
    while (!(imem_rvalid && m_pend && !m_drop) && n < 40) begin next(); n++; end
    if (n >= 40) timeout("t4_wait");
    redirect_valid = 1; redirect_pc = 32'h40;
    next();
    redirect_valid = 0;
    clear_q();
    chk("t4_valid", 32'(if_valid), 32'd0);
    chk("t4_addr", imem_addr, 32'h40);
    chk("t4_req", 32'(imem_req), 32'd1);
    n = 0;
    while (q_pc.size() < 1 && n < 40) begin next(); n++; end
    if (n >= 40) timeout("t4_refetch");
    chk("t4_if_pc", qat(q_pc, 0), 32'h40);

    // fetch_en drop mid-access: access completes, no new request
    lat = 2;
    n = 0;
    while (!m_pend && n < 40) begin next(); n++; end
    fetch_en = 0;
    id_ready = 0;
    for (int i = 0; i < 5; i++) next();
    chk("t7_idle_req", 32'(imem_req), 32'd0);
    chk("t7_landed", 32'(if_valid), 32'd1);
    id_ready = 1;
    fetch_en = 1;
    next();

    // Asynchronous reset during an outstanding access
    n = 0;
    while (!(m_pend && !m_drop) && n < 40) begin next(); n++; end
    if (n >= 40) timeout("t6_wait");
    rst_n = 0;
    fetch_en = 0;
    #1;
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_valid", 32'(if_valid), 32'd0);
    chk("t6_pc", if_pc, 32'h0);
    chk("t6_pc_next", if_pc_next, 32'h1);
    next();
    rst_n = 1;
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    next();
    imem_rvalid = 0;
    next();
    chk("t6_late_ignored", 32'(if_valid), 32'd0);
    fetch_en = 1;
    clear_q();
    n = 0;
    while (q_pc.size() < 1 && n < 40) begin next(); n++; end
    if (n >= 40) timeout("t6_restart");
    chk("t6_restart_addr", qat(q_addr, 0), 32'h0);
    chk("t6_restart_pc", qat(q_pc, 0), 32'h0);

    next();
    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
